// File: rtl/mem_multimode_rw.sv
// Word-addressed RAM with byte-lane writes, bit/byte/halfword/word reads and a post-reset clear.
// Define MEM_MULTIMODE_PARITY_EN to add per-byte even parity with ParErrInj/ParErr.
module mem_multimode_rw #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 256,
  localparam int unsigned NB     = DATA_W / 8,
  localparam int unsigned BIT_W  = $clog2(DATA_W),
  localparam int unsigned BYTE_W = $clog2(NB)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              WrEn,
  input  logic [NB-1:0]     WrByteEn,
  input  logic              RdEn,
  input  logic [1:0]        RdEn_Opcode,
  input  logic [BIT_W-1:0]  BitAddr,
  input  logic [BYTE_W-1:0] ByteAddr,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WrBus,
  output logic [DATA_W-1:0] RdBus,
  output logic              RdValid,
  output logic              AddrErr,
  output logic              Busy
`ifdef MEM_MULTIMODE_PARITY_EN
  ,
  input  logic              ParErrInj,
  output logic              ParErr
`endif
);

  localparam int unsigned CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(DEPTH - 1);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rd_bus_q, rd_bus_d;
  logic              rd_valid_q, rd_valid_d;
  logic              addr_err_q, addr_err_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              run;
  logic              in_range;
  logic [CNT_W-1:0]  addr_idx;
  logic              wr_ok;
  logic              rd_ok;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rd_shift;
  logic [DATA_W-1:0] rd_sel;
  logic [BYTE_W-1:0] half_idx;

  assign run      = (state_q == StRun);
  // Compare one bit wider so DEPTH == 2**ADDR_W fits and never flags.
  assign in_range = ({1'b0, Addr} < DEPTH_EXT);
  assign addr_idx = Addr[CNT_W-1:0];
  assign wr_ok    = run && WrEn && in_range;
  assign rd_ok    = run && RdEn;
  assign rd_word  = mem_q[addr_idx];
  assign half_idx = ByteAddr >> 1;

  // Storage has no reset; INIT zero-fills one word per cycle instead.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_ok) begin
      for (int b = 0; b < NB; b++) begin
        if (WrByteEn[b]) mem_q[addr_idx][8*b +: 8] <= WrBus[8*b +: 8];
      end
    end
  end

  always_comb begin
    rd_sel   = '0;
    rd_shift = '0;
    unique case (RdEn_Opcode)
      2'd0: begin
        rd_shift  = rd_word >> BitAddr;
        rd_sel[0] = rd_shift[0];
      end
      2'd1: rd_sel = rd_word;
      2'd2: begin
        rd_shift    = rd_word >> {ByteAddr, 3'b000};
        rd_sel[7:0] = rd_shift[7:0];
      end
      2'd3: begin
        rd_shift     = rd_word >> {half_idx, 4'b0000};
        rd_sel[15:0] = rd_shift[15:0];
      end
      default: rd_sel = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_valid_d = rd_ok;
    addr_err_d = run && (WrEn || RdEn) && !in_range;
    rd_bus_d   = rd_bus_q;
    if (rd_ok) rd_bus_d = in_range ? rd_sel : '0;
    if (state_q == StInit) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST_IDX) begin
        state_d = StRun;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StInit;
      cnt_q      <= '0;
      rd_bus_q   <= '0;
      rd_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_bus_q   <= rd_bus_d;
      rd_valid_q <= rd_valid_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign RdBus   = rd_bus_q;
  assign RdValid = rd_valid_q;
  assign AddrErr = addr_err_q;
  assign Busy    = (state_q == StInit);

`ifdef MEM_MULTIMODE_PARITY_EN
  logic [NB-1:0] par_q [DEPTH];
  logic          par_bad;
  logic          par_err_q;

  always_ff @(posedge clk) begin
    if (!run) begin
      par_q[cnt_q] <= '0;
    end else if (wr_ok) begin
      for (int b = 0; b < NB; b++) begin
        if (WrByteEn[b]) par_q[addr_idx][b] <= (^WrBus[8*b +: 8]) ^ ParErrInj;
      end
    end
  end

  always_comb begin
    par_bad = 1'b0;
    for (int b = 0; b < NB; b++) begin
      par_bad = par_bad | (^{rd_word[8*b +: 8], par_q[addr_idx][b]});
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) par_err_q <= 1'b0;
    else        par_err_q <= rd_ok && in_range && par_bad;
  end

  assign ParErr = par_err_q;
`endif

endmodule

// File: tb/tb_mem_multimode_rw.sv
// Scoreboard bench for mem_multimode_rw at default parameters (DATA_W=32, DEPTH=256).
module tb_mem_multimode_rw;

  logic        clk = 1'b0;
  logic        reset;
  logic        WrEn;
  logic [3:0]  WrByteEn;
  logic        RdEn;
  logic [1:0]  RdEn_Opcode;
  logic [4:0]  BitAddr;
  logic [1:0]  ByteAddr;
  logic [15:0] Addr;
  logic [31:0] WrBus;
  logic [31:0] RdBus;
  logic        RdValid;
  logic        AddrErr;
  logic        Busy;
`ifdef MEM_MULTIMODE_PARITY_EN
  logic        ParErrInj;
  logic        ParErr;
`endif

  mem_multimode_rw dut (
    .clk        (clk),
    .reset      (reset),
    .WrEn       (WrEn),
    .WrByteEn   (WrByteEn),
    .RdEn       (RdEn),
    .RdEn_Opcode(RdEn_Opcode),
    .BitAddr    (BitAddr),
    .ByteAddr   (ByteAddr),
    .Addr       (Addr),
    .WrBus      (WrBus),
    .RdBus      (RdBus),
    .RdValid    (RdValid),
    .AddrErr    (AddrErr),
    .Busy       (Busy)
`ifdef MEM_MULTIMODE_PARITY_EN
    ,
    .ParErrInj  (ParErrInj),
    .ParErr     (ParErr)
`endif
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] sb[$];
  logic [31:0] mdl [256];
  logic        run    = 1'b0;
  logic        mon_en = 1'b0;
  logic        pend_v = 1'b0;
  logic        pend_e = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_rd(input int op, input int sel, input int addr);
    logic [31:0] w;
    if (addr >= 256) return 32'h0;
    w = mdl[addr];
    case (op)
      0:       return (w >> (sel % 32)) & 32'h1;
      1:       return w;
      2:       return (w >> (8 * (sel % 4))) & 32'hFF;
      default: return (w >> (16 * ((sel % 4) / 2))) & 32'hFFFF;
    endcase
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 256; i++) mdl[i] = 32'h0;
  endtask

  // One bus cycle, driven on the falling edge; expected read data goes to the scoreboard.
  task automatic drive(input int we, input int re, input int op, input int sel, input int addr,
                       input logic [31:0] wdata, input logic [3:0] be, input logic [31:0] exp);
    logic [31:0] sv;
    @(negedge clk);
    sv          = sel;
    WrEn        = (we != 0);
    RdEn        = (re != 0);
    RdEn_Opcode = op[1:0];
    BitAddr     = sv[4:0];
    ByteAddr    = sv[1:0];
    Addr        = addr[15:0];
    WrBus       = wdata;
    WrByteEn    = be;
    pend_v      = run && (re != 0);
    pend_e      = run && ((we != 0) || (re != 0)) && (addr >= 256);
    if (pend_v) sb.push_back((addr < 256) ? exp : 32'h0);
    if (run && (we != 0) && (addr < 256)) begin
      for (int b = 0; b < 4; b++) if (be[b]) mdl[addr][8*b +: 8] = wdata[8*b +: 8];
    end
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic wait_busy(input string tag);
    int n;
    n = 0;
    while (Busy && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, n, 256);
  endtask

  always @(posedge clk) begin
    logic ev, ee;
    logic [31:0] e;
    ev = pend_v;
    ee = pend_e;
    #1;
    if (mon_en) begin
      check("rd_valid", RdValid, ev);
      check("addr_err", AddrErr, ee);
      if (RdValid) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          check("rd_bus", RdBus, e);
        end
      end
    end
  end

  initial begin
    int we, re, op, sel, addr;
    logic [31:0] wd, ex;
    logic [3:0]  be;

    reset = 1'b0; WrEn = 1'b0; RdEn = 1'b0; RdEn_Opcode = 2'd0; BitAddr = '0;
    ByteAddr = '0; Addr = '0; WrBus = '0; WrByteEn = '0;
`ifdef MEM_MULTIMODE_PARITY_EN
    ParErrInj = 1'b0;
`endif
    #2;
    check("rst_rdbus", RdBus, 0);
    check("rst_valid", RdValid, 0);
    check("rst_addrerr", AddrErr, 0);
    check("rst_busy", Busy, 1);
    mon_en = 1'b1;

    // Requests held during INIT must be ignored entirely.
    WrEn = 1'b1; RdEn = 1'b1; Addr = 16'h0005; WrBus = 32'hFFFF_FFFF; WrByteEn = 4'hF;
    @(negedge clk);
    reset = 1'b1;
    wait_busy("busy_len");
    clear_model();
    run = 1'b1;

    drive(0, 1, 1, 0, 16'h00FF, 0, 0, 32'h0000_0000);
    drive(0, 1, 1, 0, 16'h0005, 0, 0, 32'h0000_0000);

    drive(1, 0, 0, 0, 16'h0010, 32'hA5C3_1E7F, 4'hF, 0);
    drive(0, 1, 1, 0,  16'h0010, 0, 0, 32'hA5C3_1E7F);
    drive(0, 1, 2, 2,  16'h0010, 0, 0, 32'h0000_00C3);
    drive(0, 1, 3, 3,  16'h0010, 0, 0, 32'h0000_A5C3);
    drive(0, 1, 0, 31, 16'h0010, 0, 0, 32'h0000_0001);
    drive(1, 0, 0, 0, 16'h0010, 32'hFFFF_FFFF, 4'b0101, 0);
    drive(0, 1, 1, 0, 16'h0010, 0, 0, 32'hA5FF_1EFF);
    idle();

    drive(1, 0, 0, 0, 16'h0020, 32'h1111_1111, 4'hF, 0);
    drive(1, 1, 1, 0, 16'h0020, 32'h2222_2222, 4'hF, 32'h1111_1111);
    drive(0, 1, 1, 0, 16'h0020, 0, 0, 32'h2222_2222);

    drive(1, 0, 0, 0, 16'h0100, 32'hDEAD_BEEF, 4'hF, 0);
    idle();
    drive(0, 1, 1, 0, 16'h0100, 0, 0, 32'h0);
    drive(0, 1, 1, 0, 16'h0000, 0, 0, 32'h0);

    for (int i = 0; i < 300; i++) begin
      we   = $urandom % 2;
      re   = (($urandom % 4) != 0) ? 1 : 0;
      op   = $urandom % 4;
      sel  = $urandom % 32;
      addr = (($urandom % 16) == 0) ? 256 + ($urandom % 8) : ($urandom % 16);
      wd   = $urandom;
      be   = 4'($urandom % 16);
      ex   = model_rd(op, sel, addr);
      drive(we, re, op, sel, addr, wd, be, ex);
    end
    idle();
    idle();

    // Reset in RUN with a read already on the bus: the read must be dropped.
    drive(0, 1, 1, 0, 16'h0010, 0, 0, model_rd(1, 0, 16'h0010));
    @(negedge clk);
    run = 1'b0; pend_v = 1'b0; pend_e = 1'b0;
    RdEn = 1'b1; Addr = 16'h0003; reset = 1'b0;
    #1;
    check("run_rst_valid", RdValid, 0);
    check("run_rst_busy", Busy, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("mid_init_busy", Busy, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", Busy, 1);
    @(negedge clk);
    reset = 1'b1;
    wait_busy("busy_restart");
    clear_model();
    run = 1'b1;
    drive(0, 1, 1, 0, 16'h0010, 0, 0, 32'h0);
    drive(0, 1, 1, 0, 16'h0020, 0, 0, 32'h0);

`ifdef MEM_MULTIMODE_PARITY_EN
    drive(1, 0, 0, 0, 16'h0030, 32'h1234_5678, 4'hF, 0);
    drive(0, 1, 1, 0, 16'h0030, 0, 0, 32'h1234_5678);
    @(posedge clk);
    #2;
    check("par_clean", ParErr, 0);
    @(negedge clk);
    ParErrInj = 1'b1;
    drive(1, 0, 0, 0, 16'h0031, 32'h0000_00FF, 4'h1, 0);
    ParErrInj = 1'b0;
    drive(0, 1, 2, 1, 16'h0031, 0, 0, 32'h0);
    @(posedge clk);
    #2;
    check("par_inject", ParErr, 1);
`endif

    repeat (3) idle();
    @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_multimode_rw.md
Name: mem_multimode_rw

Overview:
- Parametrised successor to the single-port bit/byte/word memory.
- Synchronous word-addressed RAM with:
  - per-byte write enables
  - four read modes: bit, byte, halfword, word
  - registered read with a valid strobe
  - a post-reset hardware clear sequence that zero-fills every word
  - out-of-range address detection for non-power-of-two depths
- Sits as the storage block behind the lab datapath; the bench drives it directly.

Parameters:
- DATA_W, 32, word width in bits; multiple of 16, at least 16.
- ADDR_W, 16, address bus width.
- DEPTH, 256, number of words implemented; 1 <= DEPTH <= 2**ADDR_W.
- Derived locals:
  - NB = DATA_W/8
  - BIT_W = clog2(DATA_W)
  - BYTE_W = clog2(NB)

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- WrEn  in  1  write request, sampled at posedge.
- WrByteEn  in  NB  byte lane mask for writes; bit b enables WrBus[8b+7:8b].
- RdEn  in  1  read request, sampled at posedge.
- RdEn_Opcode  in  2  read mode: 0 bit, 1 word, 2 byte, 3 halfword.
- BitAddr  in  BIT_W  bit select within word (mode 0).
- ByteAddr  in  BYTE_W  byte select (mode 2); ByteAddr[BYTE_W-1:1] selects the halfword (mode 3).
- Addr  in  ADDR_W  word address.
- WrBus  in  DATA_W  write data.
- RdBus  out  DATA_W  read data, registered, zero-extended.
- RdValid  out  1  one-cycle pulse, coincident with new RdBus.
- AddrErr  out  1  one-cycle pulse: the previous-cycle access had Addr >= DEPTH.
- Busy  out  1  high while the clear sequence runs.

Behaviour:
- Reset (reset=0, async):
  - RdBus=0, RdValid=0, AddrErr=0, Busy=1.
  - FSM forced to INIT, clear counter=0.
  - Memory contents are not touched asynchronously.
- FSM INIT:
  - Each cycle writes 0 to mem[cnt], then cnt++.
  - When cnt==DEPTH-1 is written, go to RUN.
  - Busy drops to 0 the cycle after the last clear write: DEPTH cycles after the first posedge with reset=1.
  - WrEn/RdEn are ignored in INIT: no write, no RdValid, no AddrErr.
- FSM RUN: stays in RUN until reset is asserted.
- Reset asserted mid-INIT or mid-RUN restarts INIT from cnt=0. Any in-flight read is dropped (RdValid=0).
- Write (RUN, WrEn=1, Addr<DEPTH): for each b with WrByteEn[b]=1, mem[Addr] byte b <= WrBus byte b. Other bytes are unchanged.
- Read (RUN, RdEn=1, Addr<DEPTH): one-cycle latency. At the next posedge, RdValid=1 and RdBus =
  - mode 0: {0, mem[Addr][BitAddr]}
  - mode 1: mem[Addr]
  - mode 2: {0, byte ByteAddr}
  - mode 3: {0, halfword ByteAddr[BYTE_W-1:1]}; ByteAddr[0] is ignored.
- RdBus holds its last value when RdValid=0.
- Simultaneous WrEn and RdEn to the same Addr: both execute; the read returns pre-write data (read-before-write).
- Addr >= DEPTH:
  - Write is discarded.
  - A read returns RdBus=0 with RdValid=1.
  - AddrErr=1 in the following cycle for either access type.
  - With DEPTH=2**ADDR_W, AddrErr can never assert.
- Back-to-back reads every cycle are supported: RdValid stays high continuously.

Optional Feature:
- Macro: MEM_MULTIMODE_PARITY_EN.
- Defined:
  - Adds one stored even-parity bit per byte, written with each enabled lane and cleared (parity 0) in INIT.
  - Adds input ParErrInj (1): when high during a write, the stored parity of every written lane is inverted.
  - Adds output ParErr (1): asserted with RdValid if any byte of the addressed word fails parity. The check covers the full word regardless of mode.
- Undefined:
  - No parity storage and no ParErrInj/ParErr ports.
  - Behaviour otherwise identical.

Test Plan:
- Release reset with DEPTH=256:
  - Busy=1 for exactly 256 cycles, then 0.
  - Read mode 1 at Addr 0x00FF returns 0x00000000 with RdValid=1.
- Write Addr=0x0010, WrBus=0xA5C3_1E7F, WrByteEn=4'b1111, then read:
  - mode 1 -> 0xA5C31E7F
  - mode 2 ByteAddr=2 -> 0x000000C3
  - mode 3 ByteAddr=3 -> 0x0000A5C3
  - mode 0 BitAddr=31 -> 0x00000001
- Write Addr=0x0010, WrBus=0xFFFF_FFFF, WrByteEn=4'b0101, then read mode 1 -> 0xA5FF1EFF.
- Same-cycle WrEn+RdEn to Addr 0x0020 (old 0x11111111, new 0x22222222):
  - RdBus=0x11111111.
  - The next read returns 0x22222222.
- Write Addr=0x0100 (DEPTH=256): discarded; AddrErr pulses one cycle. A read at 0x0100 gives RdBus=0, RdValid=1, AddrErr=1.
- Assert reset at cycle 100 of INIT: Busy stays 1 and the clear restarts, completing 256 cycles after release. With MEM_MULTIMODE_PARITY_EN defined, a write with ParErrInj=1 followed by a read gives ParErr=1.
